// File: rtl/hilo_mul_sequencer.sv
// rtl/hilo_mul_sequencer.sv - HI/LO owner and step sequencer for the shift-add MULTU/MADDU multiplier
module hilo_mul_sequencer #(
   parameter int WIDTH = 32,
   parameter int STEPS = 32,
   parameter int CNTW  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_valid,
   input  logic [5:0]         funct,
   input  logic [2*WIDTH-1:0] mul_prod,
   output logic               op_ready,
   output logic               busy,
   output logic               mul_load,
   output logic               mul_step,
   output logic               hilo_we,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic [WIDTH-1:0]   mf_data
);

   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MADDU = 6'b011100;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              kind_q, kind_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

   logic is_mul, is_mf, accept;

   assign is_mul = (funct == F_MULTU) || (funct == F_MADDU);
   assign is_mf  = (funct == F_MFHI) || (funct == F_MFLO);
   assign accept = op_valid && op_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         kind_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && is_mul) begin
               kind_d  = (funct == F_MADDU);
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(STEPS - 1)) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // MADDU accumulates across the full 2*WIDTH so lo carries into hi
            if (kind_q) begin
               {hi_d, lo_d} = {hi_q, lo_q} + mul_prod;
            end else begin
               {hi_d, lo_d} = mul_prod;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != S_IDLE);
      op_ready = !(busy && op_valid && (is_mul || is_mf));
      mul_load = (state_q == S_IDLE) && accept && is_mul;
      mul_step = (state_q == S_RUN);
      hilo_we  = (state_q == S_WRITE);
      if (funct == F_MFHI) begin
         mf_data = hi_q;
      end else if (funct == F_MFLO) begin
         mf_data = lo_q;
      end else begin
         mf_data = '0;
      end
   end

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// tb/tb_hilo_mul_sequencer.sv - self-checking bench for hilo_mul_sequencer
module tb_hilo_mul_sequencer;

   localparam int STEPS = 32;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MADDU = 6'b011100;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_ADD   = 6'd32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_valid = 1'b0;
   logic [5:0]  funct = 6'd0;
   logic [63:0] mul_prod = 64'd0;
   logic        op_ready, busy, mul_load, mul_step, hilo_we, done;
   logic [31:0] hi, lo, mf_data;

   hilo_mul_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .funct    (funct),
      .mul_prod (mul_prod),
      .op_ready (op_ready),
      .busy     (busy),
      .mul_load (mul_load),
      .mul_step (mul_step),
      .hilo_we  (hilo_we),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .mf_data  (mf_data)
   );

   always #5 clk = ~clk;

   // Reference: an in-flight op started at cycle m_t is busy for cycles m_t+1 .. m_t+STEPS+1
   int          cyc = 0;
   logic        m_infl = 1'b0;
   int          m_t = 0;
   logic        m_kind = 1'b0;
   logic [63:0] m_hilo = 64'd0;
   int          m_tdone = -1;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] cur_prod = 64'd0;
   int          load_cyc = -1, we_cyc = -1, done_cyc = -1, step_cnt = 0;

   function automatic logic is_mul(input logic [5:0] f);
      return (f == F_MULTU) || (f == F_MADDU);
   endfunction

   function automatic logic is_mf(input logic [5:0] f);
      return (f == F_MFHI) || (f == F_MFLO);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_infl  <= 1'b0;
         m_hilo  <= 64'd0;
         m_tdone <= -1;
      end else if (m_infl && (cyc - m_t == STEPS + 1)) begin
         m_hilo  <= m_kind ? (m_hilo + mul_prod) : mul_prod;
         m_infl  <= 1'b0;
         m_tdone <= cyc + 1;
      end else if (!m_infl && op_valid && is_mul(funct)) begin
         m_infl <= 1'b1;
         m_t    <= cyc;
         m_kind <= (funct == F_MADDU);
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic compare_all();
      int          rel;
      logic [31:0] e_mf;
      if (rst) begin
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_load", 64'(mul_load), 64'd0);
         chk("rst_step", 64'(mul_step), 64'd0);
         chk("rst_we", 64'(hilo_we), 64'd0);
         chk("rst_done", 64'(done), 64'd0);
         chk("rst_ready", 64'(op_ready), 64'd1);
         chk("rst_hilo", {hi, lo}, 64'd0);
      end else begin
         rel = cyc - m_t;
         if (funct == F_MFHI)      e_mf = m_hilo[63:32];
         else if (funct == F_MFLO) e_mf = m_hilo[31:0];
         else                      e_mf = 32'd0;
         chk("busy", 64'(busy), 64'(m_infl));
         chk("mul_step", 64'(mul_step), 64'(m_infl && rel <= STEPS));
         chk("hilo_we", 64'(hilo_we), 64'(m_infl && rel == STEPS + 1));
         chk("done", 64'(done), 64'(cyc == m_tdone));
         chk("mul_load", 64'(mul_load), 64'(!m_infl && op_valid && is_mul(funct)));
         chk("op_ready", 64'(op_ready),
             64'(!(m_infl && op_valid && (is_mul(funct) || is_mf(funct)))));
         chk("mf_data", 64'(mf_data), 64'(e_mf));
         chk("hilo", {hi, lo}, m_hilo);
         if (mul_load) begin
            load_cyc = cyc;
            step_cnt = 0;
         end
         if (mul_step) step_cnt++;
         if (hilo_we)  we_cyc = cyc;
         if (done)     done_cyc = cyc;
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [5:0] f);
      op_valid = v;
      funct    = f;
      if (m_infl && (cyc - m_t == STEPS + 1)) mul_prod = cur_prod;
      else mul_prod = {$urandom, $urandom};
   endtask

   task automatic issue(input logic [5:0] f, input logic [63:0] p, output int ta);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      ta  = -1;
      while (!acc && n < 200) begin
         acc = !m_infl;
         ta  = cyc;
         set_in(1'b1, f);
         step();
         n++;
      end
      chk("issue_timeout", 64'(acc), 64'd1);
      cur_prod = p;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_infl && n < 200) begin
         set_in(1'b0, 6'd0);
         step();
         n++;
      end
      chk("idle_timeout", 64'(m_infl), 64'd0);
      set_in(1'b0, 6'd0);
      step();
   endtask

   initial begin
      int          ta, tb2, n, r, old_we, old_done;
      logic        v, acc;
      logic [5:0]  f;
      logic [5:0]  ftab [5];
      ftab = '{F_MULTU, F_MADDU, F_MFHI, F_MFLO, F_ADD};

      set_in(1'b0, 6'd0);
      step();
      step();
      rst = 1'b0;
      set_in(1'b0, 6'd0);
      step();

      issue(F_MULTU, 64'd15, ta);
      wait_idle();
      chk("t_load", 64'(load_cyc), 64'(ta));
      chk("t_steps", 64'(step_cnt), 64'd32);
      chk("t_we", 64'(we_cyc), 64'(ta + 33));
      chk("t_done", 64'(done_cyc), 64'(ta + 34));
      chk("multu_hi", 64'(hi), 64'd0);
      chk("multu_lo", 64'(lo), 64'd15);
      chk("model_multu", m_hilo, 64'd15);

      issue(F_MADDU, 64'hFFFFFFFE_00000001, ta);
      wait_idle();
      chk("maddu_hi", 64'(hi), 64'hFFFFFFFE);
      chk("maddu_lo", 64'(lo), 64'h00000010);
      chk("model_maddu", m_hilo, 64'hFFFFFFFE_00000010);

      issue(F_MULTU, 64'h00000000_FFFFFFFF, ta);
      wait_idle();
      issue(F_MADDU, 64'd1, ta);
      wait_idle();
      chk("carry_hi", 64'(hi), 64'd1);
      chk("carry_lo", 64'(lo), 64'd0);

      issue(F_MULTU, 64'd1, ta);
      wait_idle();
      issue(F_MADDU, 64'hFFFFFFFF_FFFFFFFF, ta);
      wait_idle();
      chk("wrap_hilo", {hi, lo}, 64'd0);
      chk("model_wrap", m_hilo, 64'd0);

      issue(F_MULTU, 64'h00000007_00001234, ta);
      n = 0;
      while (m_infl && n < 200) begin
         set_in(1'b1, F_MFLO);
         #2;
         chk("mflo_stall_ready", 64'(op_ready), 64'd0);
         step();
         n++;
      end
      chk("mflo_stall_cycles", 64'(n), 64'd33);
      chk("mflo_accept_cyc", 64'(cyc - ta), 64'd34);
      set_in(1'b1, F_MFLO);
      #2;
      chk("mflo_ready", 64'(op_ready), 64'd1);
      chk("mflo_data", 64'(mf_data), 64'h1234);
      step();
      set_in(1'b1, F_MFHI);
      #2;
      chk("mfhi_data", 64'(mf_data), 64'd7);
      step();

      issue(F_MULTU, 64'hAAAA, ta);
      set_in(1'b1, F_ADD);
      #2;
      chk("add_ready", 64'(op_ready), 64'd1);
      step();
      issue(F_MULTU, 64'h5555, tb2);
      chk("b2b_gap", 64'(tb2 - ta), 64'd34);
      chk("b2b_load", 64'(load_cyc), 64'(tb2));
      wait_idle();
      chk("b2b_lo", 64'(lo), 64'h5555);

      issue(F_MULTU, 64'h63, ta);
      while (cyc < ta + 11) begin
         set_in(1'b0, 6'd0);
         step();
      end
      old_we   = we_cyc;
      old_done = done_cyc;
      rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      set_in(1'b0, 6'd0);
      step();
      rst = 1'b0;
      repeat (40) begin
         set_in(1'b0, 6'd0);
         step();
      end
      chk("midrst_no_we", 64'(we_cyc), 64'(old_we));
      chk("midrst_no_done", 64'(done_cyc), 64'(old_done));
      issue(F_MULTU, 64'h00000001_00000005, ta);
      wait_idle();
      chk("post_rst_hi", 64'(hi), 64'd1);
      chk("post_rst_lo", 64'(lo), 64'd5);

      for (int i = 0; i < 2500; i++) begin
         r = $urandom_range(0, 299);
         if (r == 0) begin
            rst = 1'b1;
            set_in(1'b0, 6'd0);
            step();
            rst = 1'b0;
         end else begin
            v = (r < 180);
            if ($urandom_range(0, 5) == 5) f = 6'($urandom);
            else f = ftab[$urandom_range(0, 4)];
            acc = v && is_mul(f) && !m_infl;
            set_in(v, f);
            step();
            if (acc) cur_prod = {$urandom, $urandom};
         end
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
